// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared helpers for the bnn_fcc input binarizer
package bnn_pkg;

  function automatic int ppb(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int words_per_image(input int image_size, input int parallel_inputs);
    return (image_size + parallel_inputs - 1) / parallel_inputs;
  endfunction

  // Width able to hold values 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic binarize(input logic [31:0] pixel, input logic [31:0] thr);
    return pixel >= thr;
  endfunction

endpackage

// File: rtl/bnn_input_binarizer.sv
// rtl/bnn_input_binarizer.sv - thresholds streamed pixels to bits and packs them into words
module bnn_input_binarizer
  import bnn_pkg::*;
#(
  parameter int          INPUT_DATA_WIDTH = 16,
  parameter int          INPUT_BUS_WIDTH  = 32,
  parameter int          PARALLEL_INPUTS  = 8,
  parameter int          IMAGE_SIZE       = 784,
  parameter int unsigned BIN_THRESHOLD    = 32'd1 << (INPUT_DATA_WIDTH - 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_BUS_WIDTH-1:0]   in_data,
  input  logic [INPUT_BUS_WIDTH/8-1:0] in_keep,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PARALLEL_INPUTS-1:0]   out_data,
  output logic                         out_last,
  output logic                         err
);

  localparam int PPB    = ppb(INPUT_BUS_WIDTH, INPUT_DATA_WIDTH);
  localparam int P      = PARALLEL_INPUTS;
  localparam int FILL_W = cnt_width(P);
  localparam int CNT_W  = cnt_width(IMAGE_SIZE);

  if (P % PPB != 0) begin : g_bad_parallel
    $error("PARALLEL_INPUTS must be a multiple of pixels per beat");
  end
  if (IMAGE_SIZE % PPB != 0) begin : g_bad_image
    $error("IMAGE_SIZE must be a multiple of pixels per beat");
  end

  logic [P-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  pixel_cnt_q, pixel_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [P-1:0]      out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;

  logic [PPB-1:0]    beat_bits;
  logic [P-1:0]      acc_merged;
  logic [FILL_W-1:0] fill_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              image_end;
  logic              word_full;
  logic              beat_accept;

  assign in_ready    = !out_valid_q || out_ready;
  assign beat_accept = in_valid && in_ready;

  always_comb begin
    beat_bits = '0;
    for (int j = 0; j < PPB; j++) begin
      beat_bits[j] = binarize(32'(in_data[j*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]), BIN_THRESHOLD);
    end
    // Fill is always a multiple of PPB and the accumulator is cleared on close, so OR-in is safe
    acc_merged = acc_q | (P'(beat_bits) << fill_q);
    fill_next  = fill_q + FILL_W'(PPB);
    cnt_next   = pixel_cnt_q + CNT_W'(PPB);
    image_end  = (cnt_next == CNT_W'(IMAGE_SIZE));
    word_full  = (fill_next == FILL_W'(P));
  end

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    pixel_cnt_d = pixel_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;

    if (beat_accept) begin
      if (image_end || word_full) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_merged;
        out_last_d  = image_end;
        acc_d       = '0;
        fill_d      = '0;
        pixel_cnt_d = image_end ? '0 : cnt_next;
      end else begin
        acc_d       = acc_merged;
        fill_d      = fill_next;
        pixel_cnt_d = cnt_next;
      end
      // Framing comes from the pixel counter; in_last and in_keep are only audited
      if ((in_last != image_end) || (in_keep != '1)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      pixel_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      pixel_cnt_q <= pixel_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bnn_input_binarizer.sv
// tb/tb_bnn_input_binarizer.sv - self-checking bench for bnn_input_binarizer
module tb_bnn_input_binarizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_r = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = 4'hF;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;

  logic       m_in_ready, m_out_valid, m_out_last, m_err;
  logic [7:0] m_out_data;
  logic       s_in_ready, s_out_valid, s_out_last, s_err;
  logic [7:0] s_out_data;

  logic       cur_in_ready, cur_out_valid, cur_out_last, cur_err;
  logic [7:0] cur_out_data;

  logic [15:0] img [0:1567];
  logic [8:0]  exp_q[$];
  logic [8:0]  got[$];
  int          checks = 0;
  int          errors = 0;
  int          probe_beat = -1;
  int          probe_state = 0;
  logic        err_at_probe, err_after_probe;

  always #5 clk = ~clk;

  bnn_input_binarizer u_main (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r && !sel), .in_ready(m_in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(m_out_valid), .out_ready(out_ready),
    .out_data(m_out_data), .out_last(m_out_last), .err(m_err)
  );

  bnn_input_binarizer #(.IMAGE_SIZE(20)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_r && sel), .in_ready(s_in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_last(s_out_last), .err(s_err)
  );

  assign cur_in_ready  = sel ? s_in_ready  : m_in_ready;
  assign cur_out_valid = sel ? s_out_valid : m_out_valid;
  assign cur_out_data  = sel ? s_out_data  : m_out_data;
  assign cur_out_last  = sel ? s_out_last  : m_out_last;
  assign cur_err       = sel ? s_err       : m_err;

  // Reference: each image packed independently, pixel n -> word n/8 bit n%8, tail zero-padded
  task automatic build_expected(input int px, input int nimg);
    exp_q.delete();
    for (int im = 0; im < nimg; im++) begin
      for (int w = 0; w * 8 < px; w++) begin
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) begin
          if (w * 8 + k < px && img[im * px + w * 8 + k] >= 16'h8000) d[k] = 1'b1;
        end
        exp_q.push_back({(w * 8 + 8 >= px), d});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_stream(input int px, input int nimg, input int lim, input int last_bad,
                            input int keep_bad, input int stall_at, input int stall_len,
                            input bit rnd_stall);
    int bpi, total, idx, cyc;
    bit accepted, held;
    logic [8:0] held_word;
    bpi = px / 2;
    total = (lim >= 0) ? lim : bpi * nimg;
    idx = 0; cyc = 0; held = 0; probe_state = 0; held_word = '0;
    got.delete();
    while (1) begin
      @(negedge clk);
      if (idx < total) begin
        in_valid_r = 1'b1;
        in_data    = {img[2*idx+1], img[2*idx]};
        in_keep    = (idx == keep_bad) ? 4'b0111 : 4'b1111;
        in_last    = ((idx % bpi) == bpi - 1) ^ (idx == last_bad);
      end else begin
        in_valid_r = 1'b0;
      end
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len) &&
                  !(rnd_stall && $urandom_range(3) == 0);
      #1;
      if (probe_state == 1) begin
        err_after_probe = cur_err;
        probe_state = 2;
      end
      if (held) begin
        checks++;
        if ({cur_out_last, cur_out_data} !== held_word) begin
          errors++;
          $display("FAIL hold_stable got %h exp %h", {cur_out_last, cur_out_data}, held_word);
        end
      end
      held = cur_out_valid && !out_ready;
      held_word = {cur_out_last, cur_out_data};
      if (held) begin
        checks++;
        if (cur_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_while_held got %b exp 0", cur_in_ready);
        end
      end
      if (cur_out_valid && out_ready) got.push_back({cur_out_last, cur_out_data});
      accepted = in_valid_r && cur_in_ready;
      if (accepted && idx == probe_beat) begin
        err_at_probe = cur_err;
        probe_state = 1;
      end
      if (idx >= total && !cur_out_valid) break;
      if (cyc >= 8000) begin
        checks++; errors++;
        $display("FAIL stream_timeout got %0d beats exp %0d", idx, total);
        break;
      end
      @(posedge clk);
      if (accepted) idx++;
      cyc++;
    end
    in_valid_r = 1'b0; out_ready = 1'b1; in_last = 1'b0; in_keep = 4'hF;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 5;
    if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", m_out_valid); end
    if (m_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", m_out_data); end
    if (m_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", m_out_last); end
    if (m_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", m_err); end
    if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", m_in_ready); end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 784; i++) img[i] = (i % 2) ? 16'hFFFF : 16'h0000;
    build_expected(784, 1);
    run_stream(784, 1, -1, -1, -1, -1, 0, 1'b0);
    checks += 2;
    if (got.size() != 98) begin errors++; $display("FAIL ramp_count got %0d exp 98", got.size()); end
    if (m_err !== 1'b0) begin errors++; $display("FAIL ramp_err got %b exp 0", m_err); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i] || got[i][7:0] !== 8'hAA) begin
        errors++; $display("FAIL ramp_word[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_threshold();
    logic [15:0] pat [4];
    pat = '{16'h7FFF, 16'h8000, 16'h8001, 16'h0000};
    for (int i = 0; i < 784; i++) img[i] = pat[i % 4];
    build_expected(784, 1);
    run_stream(784, 1, -1, -1, -1, -1, 0, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL thr_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i] || got[i][7:0] !== 8'h66) begin
        errors++; $display("FAIL thr_word[%0d] got %h exp %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 784; i++) img[i] = (i % 2) ? 16'hFFFF : 16'h0000;
    build_expected(784, 1);
    run_stream(784, 1, -1, -1, -1, 100, 10, 1'b0);
    checks++;
    if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_partial();
    sel = 1'b1;
    for (int i = 0; i < 20; i++) img[i] = 16'hFFFF;
    build_expected(20, 1);
    run_stream(20, 1, -1, -1, -1, -1, 0, 1'b0);
    checks += 2;
    if (got.size() != 3) begin errors++; $display("FAIL partial_count got %0d exp 3", got.size()); end
    if (s_err !== 1'b0) begin errors++; $display("FAIL partial_err got %b exp 0", s_err); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL partial_word[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_errors();
    for (int i = 0; i < 784; i++) img[i] = 16'($urandom_range(0, 65535));
    build_expected(784, 1);
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      probe_beat = pass ? 100 : 150;
      if (pass) run_stream(784, 1, -1, 100, 200, -1, 0, 1'b0);
      else      run_stream(784, 1, -1, -1, 150, -1, 0, 1'b0);
      checks += 4;
      if (err_at_probe !== 1'b0) begin errors++; $display("FAIL err_before[%0d] got %b exp 0", pass, err_at_probe); end
      if (probe_state != 2 || err_after_probe !== 1'b1) begin
        errors++; $display("FAIL err_after[%0d] got %b exp 1", pass, err_after_probe);
      end
      if (m_err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d] got %b exp 1", pass, m_err); end
      if (got.size() != 98) begin errors++; $display("FAIL err_count[%0d] got %0d exp 98", pass, got.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL err_word[%0d][%0d] got %h exp %h", pass, i, got[i], exp_q[i]); end
      end
    end
    probe_beat = -1;
    // A final beat without in_last is also a framing error
    do_reset();
    run_stream(784, 1, -1, 391, -1, -1, 0, 1'b0);
    checks++;
    if (m_err !== 1'b1) begin errors++; $display("FAIL err_missing_last got %b exp 1", m_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 784; i++) img[i] = 16'hFFFF;
    run_stream(784, 1, 50, -1, -1, -1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 4;
    if (m_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", m_out_valid); end
    if (m_out_data !== 8'h00) begin errors++; $display("FAIL midrst_out_data got %h exp 00", m_out_data); end
    if (m_out_last !== 1'b0) begin errors++; $display("FAIL midrst_out_last got %b exp 0", m_out_last); end
    if (m_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", m_err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 784; i++) img[i] = 16'($urandom_range(0, 65535));
    build_expected(784, 1);
    run_stream(784, 1, -1, -1, -1, -1, 0, 1'b0);
    checks += 2;
    if (got.size() != 98) begin errors++; $display("FAIL midrst_count got %0d exp 98", got.size()); end
    if (m_err !== 1'b0) begin errors++; $display("FAIL midrst_err_after got %b exp 0", m_err); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1568; i++) img[i] = 16'($urandom_range(0, 65535));
    build_expected(784, 2);
    run_stream(784, 2, -1, -1, -1, -1, 0, 1'b1);
    checks += 2;
    if (got.size() != 196) begin errors++; $display("FAIL b2b_count got %0d exp 196", got.size()); end
    if (m_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", m_err); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++;
      if (got[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word[%0d] got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_threshold();
    test_backpressure();
    test_partial();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
